// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: emits PATTERN MSB first, `frames` times, one
// valid-qualified bit per beat with GAP idle cycles between beats.
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               GAP     = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  input  logic             abort,
  output logic             valid,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: valid=1 marks data_out as a live bit for exactly that cycle;
  // there is no ready, the consumer must take every qualified bit.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] IDX_MSB  = IW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] frames_left_q, frames_left_d;
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    gap_cnt_d     = gap_cnt_q;
    frames_left_d = frames_left_q;
    sent_cnt_d    = sent_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sent_cnt_d = '0;
          if (frames != '0) begin
            frames_left_d = frames;
            bit_idx_d     = IDX_MSB;
            state_d       = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        // The beat on the wire this cycle counts even if abort is also high.
        if (bit_idx_q == '0) begin
          sent_cnt_d    = sent_cnt_q + CNT_W'(1);
          frames_left_d = frames_left_q - CNT_W'(1);
          bit_idx_d     = IDX_MSB;
        end else begin
          bit_idx_d = bit_idx_q - IW'(1);
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_idx_q == '0 && frames_left_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else if (GAP > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LAST;
        end else begin
          state_d = S_SEND;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    valid_d = (state_d == S_SEND);
    data_d  = valid_d & PATTERN[bit_idx_d];
    busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      bit_idx_q     <= '0;
      gap_cnt_q     <= '0;
      frames_left_q <= '0;
      sent_cnt_q    <= '0;
      valid_q       <= 1'b0;
      data_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      frames_left_q <= frames_left_d;
      sent_cnt_q    <= sent_cnt_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign valid     = valid_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent_cnt  = sent_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: instance a (GAP=1, CNT_W=8), instance b (GAP=0, CNT_W=2).
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  logic       start_a, abort_a, valid_a, data_a, busy_a, done_a;
  logic [7:0] frames_a, sent_a;
  logic [1:0] dbg_a;
  logic       start_b, abort_b, valid_b, data_b, busy_b, done_b;
  logic [1:0] frames_b, sent_b;
  logic [1:0] dbg_b;

  logic [16:0] exp_qa[$];
  logic [16:0] exp_qb[$];
  logic [23:0] done_qa[$];
  logic [23:0] done_qb[$];

  logic [3:0] det_sh = 4'd0;
  int         det_b = 0;

  seq_pattern_tx #(.PAT_W(4), .PATTERN(4'b1011), .GAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .frames(frames_a), .abort(abort_a),
    .valid(valid_a), .data_out(data_a), .busy(busy_a), .done(done_a),
    .sent_cnt(sent_a), .dbg_state(dbg_a)
  );

  seq_pattern_tx #(.PAT_W(4), .PATTERN(4'b1011), .GAP(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .frames(frames_b), .abort(abort_b),
    .valid(valid_b), .data_out(data_b), .busy(busy_b), .done(done_b),
    .sent_cnt(sent_b), .dbg_state(dbg_b)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present expected=none (cyc %0d)", name, cyc);
  endtask

  // Expected beats {cycle, bit} and done {cycle, sent_cnt}; limit truncates an aborted run.
  task automatic push_exp(input int sel, input int s, input int n, input int limit);
    logic [3:0] pat;
    int g, b, nb;
    pat = 4'b1011;
    g   = (sel == 0) ? 1 : 0;
    b   = 4 * n;
    nb  = (limit < b) ? limit : b;
    for (int k = 0; k < nb; k++) begin
      if (sel == 0) exp_qa.push_back({16'(s + 1 + k * (g + 1)), pat[3 - (k % 4)]});
      else          exp_qb.push_back({16'(s + 1 + k * (g + 1)), pat[3 - (k % 4)]});
    end
    if (limit >= b) begin
      if (b == 0) begin
        if (sel == 0) done_qa.push_back({16'(s + 1), 8'd0});
        else          done_qb.push_back({16'(s + 1), 8'd0});
      end else begin
        if (sel == 0) done_qa.push_back({16'(s + 2 + (b - 1) * (g + 1)), 8'(n % 256)});
        else          done_qb.push_back({16'(s + 2 + (b - 1) * (g + 1)), 8'(n % 4)});
      end
    end
  endtask

  // Driver: called at a negedge; start held for `hold` cycles, frames changed after the first.
  task automatic go(input int sel, input int n, input int hold, input int limit, output int s);
    s = cyc;
    push_exp(sel, s, n, limit);
    if (sel == 0) begin start_a = 1'b1; frames_a = 8'(n); end
    else          begin start_b = 1'b1; frames_b = 2'(n); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (sel == 0) frames_a = 8'd5;
      else          frames_b = 2'd1;
    end
    if (sel == 0) start_a = 1'b0;
    else          start_b = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [16:0] e;
    logic [23:0] d;
    if (rst) begin
      if (valid_a) begin
        check("a_busy_with_valid", {31'd0, busy_a}, 32'd1);
        if (exp_qa.size() == 0) unexpected("a_beat");
        else begin
          e = exp_qa.pop_front();
          check("a_beat", {15'd0, cyc[15:0], data_a}, {15'd0, e});
        end
      end else if (data_a !== 1'b0) check("a_data_idle", {31'd0, data_a}, 32'd0);
      if (done_a) begin
        check("a_busy_at_done", {31'd0, busy_a}, 32'd0);
        if (done_qa.size() == 0) unexpected("a_done");
        else begin
          d = done_qa.pop_front();
          check("a_done", {8'd0, cyc[15:0], sent_a}, {8'd0, d});
        end
      end
      if (valid_b) begin
        check("b_busy_with_valid", {31'd0, busy_b}, 32'd1);
        if (exp_qb.size() == 0) unexpected("b_beat");
        else begin
          e = exp_qb.pop_front();
          check("b_beat", {15'd0, cyc[15:0], data_b}, {15'd0, e});
        end
        det_sh = {det_sh[2:0], data_b};
        if (det_sh == 4'b1011) begin
          det_b++;
          det_sh = 4'd0;
        end
      end else if (data_b !== 1'b0) check("b_data_idle", {31'd0, data_b}, 32'd0);
      if (done_b) begin
        check("b_busy_at_done", {31'd0, busy_b}, 32'd0);
        if (done_qb.size() == 0) unexpected("b_done");
        else begin
          d = done_qb.pop_front();
          check("b_done", {8'd0, cyc[15:0], 6'd0, sent_b}, {8'd0, d});
        end
      end
    end
  end

  initial begin
    int s;
    rst = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; frames_a = 8'd0;
    start_b = 1'b0; abort_b = 1'b0; frames_b = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_a_outputs", {27'd0, valid_a, data_a, busy_a, done_a, 1'b0}, 32'd0);
    check("rst_a_sent", {24'd0, sent_a}, 32'd0);
    check("rst_b_outputs", {28'd0, valid_b, data_b, busy_b, done_b}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // GAP=1, one frame: beats at +1,+3,+5,+7, done at +8
    go(0, 1, 1, 1000, s);
    wait_cyc(s + 10);
    check("a_sent_1frame", {24'd0, sent_a}, 32'd1);

    // GAP=0, three frames back to back; sent_cnt steps 1,2,3 and the detector sees 3
    det_b = 0;
    det_sh = 4'd0;
    go(1, 3, 1, 1000, s);
    for (int f = 1; f <= 3; f++) begin
      wait_cyc(s + 4 * f + 1);
      check("b_sent_step", {30'd0, sent_b}, 32'(f));
    end
    wait_cyc(s + 15);
    check("b_detections", 32'(det_b), 32'd3);

    // frames=0 clears sent_cnt and pulses done with no beat
    go(1, 0, 1, 1000, s);
    check("b_busy_frames0", {31'd0, busy_b}, 32'd0);
    wait_cyc(s + 4);
    check("b_sent_cleared", {30'd0, sent_b}, 32'd0);

    // start held while busy, frames changed meanwhile: exactly 8 beats, one done
    go(0, 2, 10, 1000, s);
    wait_cyc(s + 20);
    check("a_sent_held_start", {24'd0, sent_a}, 32'd2);

    // abort during the third beat of the second frame
    go(0, 3, 1, 7, s);
    wait_cyc(s + 13);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("a_valid_after_abort", {31'd0, valid_a}, 32'd0);
    check("a_busy_after_abort", {31'd0, busy_a}, 32'd0);
    repeat (6) @(negedge clk);
    check("a_sent_after_abort", {24'd0, sent_a}, 32'd1);
    check("a_state_after_abort", {30'd0, dbg_a}, 32'd0);

    // fresh start after abort runs normally
    go(0, 1, 1, 1000, s);
    wait_cyc(s + 10);
    check("a_sent_after_restart", {24'd0, sent_a}, 32'd1);

    // asynchronous reset mid-transfer
    go(0, 2, 1, 1000, s);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("a_async_rst_outputs", {28'd0, valid_a, data_a, busy_a, done_a}, 32'd0);
    check("a_async_rst_sent", {24'd0, sent_a}, 32'd0);
    exp_qa.delete();
    done_qa.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("a_idle_after_rst", {30'd0, dbg_a, busy_a}, 32'd0);

    check("a_beats_left", 32'(exp_qa.size()), 32'd0);
    check("a_dones_left", 32'(done_qa.size()), 32'd0);
    check("b_beats_left", 32'(exp_qb.size()), 32'd0);
    check("b_dones_left", 32'(done_qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
